// File: rtl/mcu_block_sequencer.sv
// mcu_block_sequencer
// Sequences entropy decoding of baseline-JPEG 8x8 blocks behind the Huffman
// symbol decoder. Accepts (run, size, raw value) symbols, applies DC
// prediction and sign extension, and emits all 64 zigzag coefficients of each
// block through a valid/ready output register. Blocks follow the MCU order:
// Y_BLOCKS luma blocks, then one Cb block, then one Cr block.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   sym_valid_in/ready_out  symbol handshake (ready is registered)
//   sym_run_in/size_in/value_in  symbol fields
//   table_sel_out           {chroma block, AC phase} to the Huffman decoder
//   restart_in              restart marker: clear predictors, restart MCU
//   coef_valid_out/ready_in coefficient handshake
//   coef_data_out/index_out/comp_out  coefficient, zigzag index, component
//   block_done_out          pulse on handshake of k=63
//   mcu_done_out            pulse on handshake of k=63 of the Cr block
//   error_out               sticky run-overflow flag
module mcu_block_sequencer #(
   parameter int Y_BLOCKS = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        sym_valid_in,
   output logic        sym_ready_out,
   input  logic [3:0]  sym_run_in,
   input  logic [3:0]  sym_size_in,
   input  logic [11:0] sym_value_in,
   output logic [1:0]  table_sel_out,
   input  logic        restart_in,
   output logic        coef_valid_out,
   input  logic        coef_ready_in,
   output logic [11:0] coef_data_out,
   output logic [5:0]  coef_index_out,
   output logic [1:0]  comp_out,
   output logic        block_done_out,
   output logic        mcu_done_out,
   output logic        error_out
);

   typedef enum logic [2:0] {DC_WAIT, AC_WAIT, ZRUN, EMIT, FILL} state_t;

   localparam logic [2:0] CB_BLK = 3'(Y_BLOCKS);
   localparam logic [2:0] CR_BLK = 3'(Y_BLOCKS + 1);

   // JPEG magnitude-category decode: a clear top bit marks a negative value.
   function automatic logic signed [11:0] extend(input logic [3:0] size,
                                                 input logic [11:0] value);
      logic [12:0] pow2;
      logic [12:0] mag;
      logic [12:0] top;
      logic [12:0] res;
      pow2 = 13'd1 << size;
      mag  = {1'b0, value} & (pow2 - 13'd1);
      top  = mag >> (size - 4'd1);
      if (size == 4'd0)  res = '0;
      else if (top[0])   res = mag;
      else               res = mag - pow2 + 13'd1;
      return res[11:0];
   endfunction

   state_t             state_q, state_d;
   logic [5:0]         k_q, k_d;
   logic [4:0]         zeros_q, zeros_d;
   logic               pend_q, pend_d;
   logic signed [11:0] pend_val_q, pend_val_d;
   logic               last_q, last_d;      // k=63 loaded, waiting for its handshake
   logic [2:0]         blk_q, blk_d;
   logic signed [11:0] pred_q [3];
   logic signed [11:0] pred_d [3];
   logic               cv_q, cv_d;
   logic signed [11:0] cdata_q, cdata_d;
   logic [5:0]         cidx_q, cidx_d;
   logic [1:0]         ccomp_q, ccomp_d;
   logic               err_q, err_d;
   logic               sym_rdy_q, sym_rdy_d;

   logic [1:0] cur_comp;
   logic       hs, out_free, end_hs, accept;

   assign cur_comp = (blk_q < CB_BLK) ? 2'd0 : ((blk_q == CB_BLK) ? 2'd1 : 2'd2);
   assign hs       = cv_q && coef_ready_in;
   assign out_free = !cv_q || coef_ready_in;
   assign end_hs   = hs && (cidx_q == 6'd63);
   assign accept   = sym_valid_in && sym_rdy_q;

   always_comb begin
      logic [4:0]         z;
      logic               p;
      logic [6:0]         span;
      logic signed [11:0] dc_val;
      state_d    = state_q;
      k_d        = k_q;
      zeros_d    = zeros_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      last_d     = last_q;
      blk_d      = blk_q;
      pred_d     = pred_q;
      cv_d       = cv_q && !coef_ready_in;
      cdata_d    = cdata_q;
      cidx_d     = cidx_q;
      ccomp_d    = ccomp_q;
      err_d      = err_q;
      z          = '0;
      p          = 1'b0;
      span       = '0;
      dc_val     = pred_q[cur_comp] + extend(sym_size_in, sym_value_in);

      case (state_q)
         DC_WAIT: begin
            if (accept) begin
               pred_d[cur_comp] = dc_val;
               cv_d    = 1'b1;
               cdata_d = dc_val;
               cidx_d  = 6'd0;
               ccomp_d = cur_comp;
               k_d     = 6'd1;
               state_d = AC_WAIT;
            end
         end
         AC_WAIT: begin
            if (accept) begin
               if (sym_run_in == 4'd0 && sym_size_in == 4'd0) begin
                  pend_d  = 1'b0;
                  state_d = FILL;
               end else begin
                  if (sym_run_in == 4'd15 && sym_size_in == 4'd0) begin
                     z = 5'd16;
                     p = 1'b0;
                  end else begin
                     z = {1'b0, sym_run_in};
                     p = 1'b1;
                  end
                  span = {1'b0, k_q} + {2'b0, z} + {6'b0, p};
                  if (span > 7'd64) begin
                     // Run would spill past k=63: flag it, discard the value
                     // and zero-fill so the block still completes.
                     err_d   = 1'b1;
                     pend_d  = 1'b0;
                     state_d = FILL;
                  end else begin
                     zeros_d    = z;
                     pend_d     = p;
                     pend_val_d = extend(sym_size_in, sym_value_in);
                     state_d    = (z == 5'd0) ? EMIT : ZRUN;
                  end
               end
            end
         end
         ZRUN: begin
            if (out_free && !last_q) begin
               cv_d    = 1'b1;
               cdata_d = '0;
               cidx_d  = k_q;
               ccomp_d = cur_comp;
               if (k_q == 6'd63) begin
                  last_d = 1'b1;
               end else begin
                  k_d     = k_q + 6'd1;
                  zeros_d = zeros_q - 5'd1;
                  if (zeros_q == 5'd1) state_d = pend_q ? EMIT : AC_WAIT;
               end
            end
         end
         EMIT: begin
            if (out_free && !last_q) begin
               cv_d    = 1'b1;
               cdata_d = pend_val_q;
               cidx_d  = k_q;
               ccomp_d = cur_comp;
               pend_d  = 1'b0;
               if (k_q == 6'd63) begin
                  last_d = 1'b1;
               end else begin
                  k_d     = k_q + 6'd1;
                  state_d = AC_WAIT;
               end
            end
         end
         FILL: begin
            if (out_free && !last_q) begin
               cv_d    = 1'b1;
               cdata_d = '0;
               cidx_d  = k_q;
               ccomp_d = cur_comp;
               if (k_q == 6'd63) last_d = 1'b1;
               else              k_d = k_q + 6'd1;
            end
         end
         default: state_d = DC_WAIT;
      endcase

      // The block ends only once coefficient 63 leaves the output register.
      if (end_hs) begin
         state_d = DC_WAIT;
         k_d     = 6'd0;
         last_d  = 1'b0;
         pend_d  = 1'b0;
         blk_d   = (blk_q == CR_BLK) ? 3'd0 : blk_q + 3'd1;
      end

      sym_rdy_d = ((state_d == DC_WAIT) || (state_d == AC_WAIT)) && !cv_d;

      if (restart_in) begin
         state_d    = DC_WAIT;
         k_d        = '0;
         zeros_d    = '0;
         pend_d     = 1'b0;
         pend_val_d = '0;
         last_d     = 1'b0;
         blk_d      = '0;
         pred_d     = '{default: '0};
         cv_d       = 1'b0;
         cdata_d    = '0;
         cidx_d     = '0;
         ccomp_d    = '0;
         err_d      = 1'b0;
         sym_rdy_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= DC_WAIT;
         k_q        <= '0;
         zeros_q    <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         last_q     <= 1'b0;
         blk_q      <= '0;
         pred_q     <= '{default: '0};
         cv_q       <= 1'b0;
         cdata_q    <= '0;
         cidx_q     <= '0;
         ccomp_q    <= '0;
         err_q      <= 1'b0;
         sym_rdy_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         zeros_q    <= zeros_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         last_q     <= last_d;
         blk_q      <= blk_d;
         pred_q     <= pred_d;
         cv_q       <= cv_d;
         cdata_q    <= cdata_d;
         cidx_q     <= cidx_d;
         ccomp_q    <= ccomp_d;
         err_q      <= err_d;
         sym_rdy_q  <= sym_rdy_d;
      end
   end

   assign sym_ready_out  = sym_rdy_q;
   assign coef_valid_out = cv_q;
   assign coef_data_out  = cdata_q;
   assign coef_index_out = cidx_q;
   assign comp_out       = ccomp_q;
   assign error_out      = err_q;
   assign table_sel_out  = {cur_comp != 2'd0, state_q != DC_WAIT};
   assign block_done_out = end_hs && !restart_in && !rst_in;
   assign mcu_done_out   = block_done_out && (blk_q == CR_BLK);

endmodule

// File: tb/tb_mcu_block_sequencer.sv
// Bench for mcu_block_sequencer with Y_BLOCKS=2: walks a full MCU plus two
// more blocks from a symbol table, then a restart sequence in a Cb block.
module tb_mcu_block_sequencer;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        sym_valid_in;
   logic        sym_ready_out;
   logic [3:0]  sym_run_in;
   logic [3:0]  sym_size_in;
   logic [11:0] sym_value_in;
   logic [1:0]  table_sel_out;
   logic        restart_in;
   logic        coef_valid_out;
   logic        coef_ready_in;
   logic [11:0] coef_data_out;
   logic [5:0]  coef_index_out;
   logic [1:0]  comp_out;
   logic        block_done_out;
   logic        mcu_done_out;
   logic        error_out;

   always #5 clk_in = ~clk_in;

   mcu_block_sequencer #(.Y_BLOCKS(2)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .sym_valid_in(sym_valid_in), .sym_ready_out(sym_ready_out),
      .sym_run_in(sym_run_in), .sym_size_in(sym_size_in), .sym_value_in(sym_value_in),
      .table_sel_out(table_sel_out), .restart_in(restart_in),
      .coef_valid_out(coef_valid_out), .coef_ready_in(coef_ready_in),
      .coef_data_out(coef_data_out), .coef_index_out(coef_index_out),
      .comp_out(comp_out), .block_done_out(block_done_out),
      .mcu_done_out(mcu_done_out), .error_out(error_out)
   );

   typedef struct {
      logic [5:0]         idx;
      logic signed [11:0] data;
      logic [1:0]         comp;
      logic               bd;
      logic               md;
   } hs_t;

   typedef struct {
      int blk;   // block this symbol belongs to
      int run;
      int size;
      int val;
      int k;     // coefficient index this symbol sets (-1: none)
      int v;     // expected coefficient value at k
   } vec_t;

   hs_t q[$];
   int  bd_cnt = 0;
   int  md_cnt = 0;
   int  checks = 0;
   int  errors = 0;
   int  expv[64];

   always @(negedge clk_in) begin
      if (coef_valid_out && coef_ready_in) begin
         hs_t h;
         h.idx  = coef_index_out;
         h.data = coef_data_out;
         h.comp = comp_out;
         h.bd   = block_done_out;
         h.md   = mcu_done_out;
         q.push_back(h);
      end
      if (block_done_out === 1'b1) bd_cnt++;
      if (mcu_done_out === 1'b1) md_cnt++;
   end

   task automatic check(input string nm, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   task automatic send_sym(input int run, input int size, input int val);
      int t;
      @(posedge clk_in); #1;
      sym_valid_in = 1'b1;
      sym_run_in   = 4'(run);
      sym_size_in  = 4'(size);
      sym_value_in = 12'(val);
      t = 0;
      while (!sym_ready_out && t < 500) begin
         @(posedge clk_in); #1;
         t++;
      end
      if (!sym_ready_out) begin
         checks++;
         errors++;
         $display("FAIL sym_accept: ready=%0d after %0d cycles, expected 1", sym_ready_out, t);
         sym_valid_in = 1'b0;
      end else begin
         @(posedge clk_in); #1;
         sym_valid_in = 1'b0;
      end
   endtask

   task automatic wait_hs(input int n);
      int t;
      t = 0;
      while (q.size() < n && t < 3000) begin
         @(posedge clk_in); #1;
         t++;
      end
      check("hs_count", q.size(), n);
   endtask

   task automatic check_block(input int b, input int comp, input int mcu);
      for (int i = 0; i < 64; i++) begin
         if (i < q.size()) begin
            check($sformatf("b%0d_k%0d_idx", b, i), int'(q[i].idx), i);
            check($sformatf("b%0d_k%0d_data", b, i), int'(q[i].data), expv[i]);
            check($sformatf("b%0d_k%0d_comp", b, i), int'(q[i].comp), comp);
            check($sformatf("b%0d_k%0d_bdone", b, i), int'(q[i].bd), (i == 63) ? 1 : 0);
            check($sformatf("b%0d_k%0d_mdone", b, i), int'(q[i].md), (i == 63) ? mcu : 0);
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[20];
      int   bc[6];
      int   bm[6];
      int   bt[6];
      int   be[6];
      int   vi;
      int   idx0, dat0, qs0, bd0, md0;

      vt = '{
         // Y0: DC +5, EOB
         '{0, 0, 3, 5, 0, 5}, '{0, 0, 0, 0, -1, 0},
         // Y1: DC diff -2 -> 3; run2/-1 at k3; ZRL; EOB
         '{1, 0, 2, 1, 0, 3}, '{1, 2, 1, 0, 3, -1}, '{1, 15, 0, 0, -1, 0}, '{1, 0, 0, 0, -1, 0},
         // Cb: DC -8; +3 at k1; 3x ZRL to k50; +1 at k59; overflowing run at k60
         '{2, 0, 4, 7, 0, -8}, '{2, 0, 2, 3, 1, 3}, '{2, 15, 0, 0, -1, 0}, '{2, 15, 0, 0, -1, 0},
         '{2, 15, 0, 0, -1, 0}, '{2, 9, 1, 1, 59, 1}, '{2, 5, 4, 8, -1, 0},
         // Cr: DC -1; +16 at k4; EOB
         '{3, 0, 1, 0, 0, -1}, '{3, 3, 5, 16, 4, 16}, '{3, 0, 0, 0, -1, 0},
         // next MCU Y0, Y1: DC size 0 keeps pred 3
         '{4, 0, 0, 0, 0, 3}, '{4, 0, 0, 0, -1, 0},
         '{5, 0, 0, 0, 0, 3}, '{5, 0, 0, 0, -1, 0}
      };
      bc = '{0, 0, 1, 2, 0, 0};   // component of each block
      bm = '{0, 0, 0, 1, 0, 0};   // mcu_done expected at k=63
      bt = '{0, 2, 2, 0, 0, 2};   // table_sel in DC_WAIT of the following block
      be = '{0, 0, 1, 1, 1, 1};   // error_out after the block

      rst_in        = 1'b1;
      restart_in    = 1'b0;
      sym_valid_in  = 1'b0;
      sym_run_in    = '0;
      sym_size_in   = '0;
      sym_value_in  = '0;
      coef_ready_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_sym_ready", sym_ready_out, 0);
      check("rst_coef_valid", coef_valid_out, 0);
      check("rst_table_sel", table_sel_out, 0);
      check("rst_error", error_out, 0);
      check("rst_block_done", block_done_out, 0);
      check("rst_mcu_done", mcu_done_out, 0);
      check("rst_coef_data", coef_data_out, 0);
      check("rst_coef_index", coef_index_out, 0);
      check("rst_comp", comp_out, 0);
      rst_in = 1'b0;
      @(posedge clk_in); #1;
      check("post_rst_sym_ready", sym_ready_out, 1);

      vi = 0;
      for (int b = 0; b < 6; b++) begin
         q.delete();
         for (int i = 0; i < 64; i++) expv[i] = 0;
         while (vi < 20 && vt[vi].blk == b) begin
            send_sym(vt[vi].run, vt[vi].size, vt[vi].val);
            if (vt[vi].k >= 0) expv[vt[vi].k] = vt[vi].v;
            if (vt[vi].k == 0)
               check($sformatf("b%0d_tsel_ac", b), table_sel_out, (bc[b] != 0) ? 3 : 1);
            vi++;
         end
         if (b == 3) begin
            // stall the zero fill for 10 cycles
            repeat (3) @(posedge clk_in);
            #1;
            coef_ready_in = 1'b0;
            idx0 = int'(coef_index_out);
            dat0 = int'($signed(coef_data_out));
            qs0  = q.size();
            for (int c = 0; c < 10; c++) begin
               @(posedge clk_in); #1;
               check("stall_valid", coef_valid_out, 1);
               check("stall_index", coef_index_out, idx0);
               check("stall_data", int'($signed(coef_data_out)), dat0);
               check("stall_sym_ready", sym_ready_out, 0);
            end
            check("stall_no_hs", q.size(), qs0);
            coef_ready_in = 1'b1;
         end
         wait_hs(64);
         check_block(b, bc[b], bm[b]);
         repeat (2) @(posedge clk_in);
         #1;
         check($sformatf("b%0d_next_tsel", b), table_sel_out, bt[b]);
         check($sformatf("b%0d_error", b), error_out, be[b]);
      end
      check("mcu_pulses", md_cnt, 1);
      check("block_pulses", bd_cnt, 6);

      // Restart in the middle of a Cb block's AC phase
      q.delete();
      send_sym(0, 1, 1);                  // Cb DC: -8 + 1 = -7
      send_sym(0, 1, 1);                  // +1 at k1
      repeat (3) @(posedge clk_in);
      #1;
      check("pre_rst_hs", q.size(), 2);
      if (q.size() >= 2) begin
         check("pre_rst_dc", int'(q[0].data), -7);
         check("pre_rst_comp", int'(q[0].comp), 1);
         check("pre_rst_k1_idx", int'(q[1].idx), 1);
         check("pre_rst_k1_data", int'(q[1].data), 1);
      end
      check("pre_rst_tsel", table_sel_out, 3);
      bd0 = bd_cnt;
      md0 = md_cnt;
      restart_in   = 1'b1;
      sym_valid_in = 1'b1;                // must not be taken during restart
      sym_run_in   = 4'd0;
      sym_size_in  = 4'd3;
      sym_value_in = 12'd5;
      @(posedge clk_in); #1;
      restart_in   = 1'b0;
      sym_valid_in = 1'b0;
      check("restart_coef_valid", coef_valid_out, 0);
      check("restart_error", error_out, 0);
      check("restart_tsel", table_sel_out, 0);
      q.delete();
      for (int i = 0; i < 64; i++) expv[i] = 0;
      expv[0] = 1;
      send_sym(0, 1, 1);                  // Y DC from cleared predictor
      send_sym(0, 0, 0);
      wait_hs(64);
      check_block(6, 0, 0);
      check("restart_no_mcu", md_cnt, md0);
      check("restart_block_pulse", bd_cnt, bd0 + 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mcu_block_sequencer.md
Name: mcu_block_sequencer

Overview:
- Sequences entropy decoding of baseline-JPEG 8x8 blocks downstream of the Huffman symbol decoder.
- Consumes (run, size, raw value) symbols and drives the decoder's table select (DC/AC, luma/chroma).
- Applies per-component DC prediction and sign extension.
- Emits all 64 coefficients per block in zigzag order with valid/ready backpressure.
- Walks the MCU schedule: Y blocks, then Cb, then Cr.

Parameters:
- Y_BLOCKS, 4, luma blocks per MCU (1..4); one Cb and one Cr block follow.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- sym_valid_in  input  1  symbol available
- sym_ready_out  output  1  symbol accepted when valid && ready
- sym_run_in  input  4  zero run (AC only; ignored for DC)
- sym_size_in  input  4  magnitude category 0..11
- sym_value_in  input  12  raw magnitude bits, LSB-aligned
- table_sel_out  output  2  bit1 = chroma block, bit0 = AC phase
- restart_in  input  1  restart marker: clear predictors, restart MCU
- coef_valid_out  output  1  coefficient held
- coef_ready_in  input  1  downstream accepts
- coef_data_out  output  12  signed coefficient (two's complement)
- coef_index_out  output  6  zigzag index k
- comp_out  output  2  0 = Y, 1 = Cb, 2 = Cr
- block_done_out  output  1  one-cycle pulse when k=63 is handshaked
- mcu_done_out  output  1  one-cycle pulse with block_done_out of the Cr block
- error_out  output  1  sticky: run overflow past k=63

Behaviour:
- Reset: all outputs 0, all predictors 0, state DC_WAIT, k=0, block counter 0, comp 0.
- Output register semantics: coef_valid_out holds with data, index and comp stable until coef_ready_in. The register loads when empty or being drained in the same cycle.
- sym_ready_out = 1 iff state is DC_WAIT or AC_WAIT and coef_valid_out = 0. It is registered, so there is a 1-cycle bubble per symbol.
- Extend: size 0 gives 0. If value[size-1] = 1, result = value. Otherwise result = value − 2^size + 1. Only bits [size-1:0] are used.
- States:
  - DC_WAIT: on accept, pred[comp] += extend (12-bit wrap). Emit pred at k=0, then k=1 and go to AC_WAIT.
  - AC_WAIT:
    - run=0, size=0 (EOB): go to FILL.
    - run=15, size=0 (ZRL): zeros_left=16, go to ZRUN with no value pending.
    - Otherwise: zeros_left=run and latch extend; go to ZRUN, or to EMIT if run=0.
    - If k + zeros_left + (value pending ? 1 : 0) > 64: set error_out, drop the value, go to FILL.
  - ZRUN: emit 0 at k per handshake, k++, zeros_left--. At 0: go to EMIT if a value is pending, else AC_WAIT.
  - EMIT: emit the value at k. If k=63, the block ends; else k++ and go to AC_WAIT.
  - FILL: emit zeros from k through 63, then the block ends.
- Block end (k=63 handshake):
  - Pulse block_done_out. Set k=0 and go to DC_WAIT.
  - Advance the block counter: 0..Y_BLOCKS−1 is Y, Y_BLOCKS is Cb, Y_BLOCKS+1 is Cr.
  - After Cr: pulse mcu_done_out and wrap the counter to 0.
- table_sel_out = {comp!=0, state!=DC_WAIT}. It updates the cycle the state changes.
- restart_in (any cycle, priority over all but rst_in):
  - Predictors cleared, counter 0, k=0, state DC_WAIT.
  - coef_valid_out cleared and error_out cleared; no done pulses.
  - Any symbol presented that cycle is not accepted.
- Simultaneous handshake and load the same cycle is legal: the back-to-back zero run reaches 1 coefficient/cycle when coef_ready_in=1.
- Reset mid-block: everything returns to reset values next cycle.

Test Plan:
- Y_BLOCKS=1, ready=1. DC size 3 value 0b101, then EOB → k0=+5, k1..63=0; 64 handshakes; block_done_out at k=63; next table_sel_out=2'b10.
- Second Y block (Y_BLOCKS=2), DC size 2 value 0b01 → diff −2, emitted DC = 3 (pred carried from +5).
- AC symbol run=2 size=1 value 0 → k1=0, k2=0, k3=−1; then ZRL → k4..k19=0; then EOB → fill to 63.
- Symbol run=5 size=4 value 0b1000 at k=60 → error_out=1, no −7/+8 emitted, k60..63=0, block completes; error_out stays 1.
- Hold coef_ready_in=0 for 10 cycles mid-run → data/index stable, sym_ready_out=0; release → sequence resumes without loss or duplication.
- restart_in asserted mid-AC of the Cb block → next symbol treated as Y DC; pred 0, so DC size 1 value 1 emits +1; mcu_done_out not pulsed.
